// File: rtl/lut_array_cfg.sv
// Array of NUM_LUTS K-input LUTs whose truth tables are loaded over one shared
// valid/ready configuration stream; outputs stay at 0 until a full load completes.
module lut_array_cfg #(
   parameter int K        = 6,
   parameter int NUM_LUTS = 8,
   parameter int CFG_W    = 8,
   parameter int REG_OUT  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_start,
   input  logic                  cfg_valid,
   input  logic [CFG_W-1:0]      cfg_data,
   output logic                  cfg_ready,
   output logic                  cfg_busy,
   output logic                  cfg_done,
   input  logic [NUM_LUTS*K-1:0] lut_in,
   output logic [NUM_LUTS-1:0]   lut_out
);

   localparam int DEPTH = 1 << K;
   localparam int LW    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

   // With CFG_W == 2^K the step truncates to 0, so every beat wraps bit_ptr.
   localparam logic [K:0]    STEP_W   = (K+1)'(CFG_W);
   localparam logic [K-1:0]  STEP     = STEP_W[K-1:0];
   localparam logic [K-1:0]  LAST_BIT = K'(DEPTH - CFG_W);
   localparam logic [LW-1:0] LAST_LUT = LW'(NUM_LUTS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t          state, state_next;
   logic [K-1:0]    bit_ptr, bit_ptr_next;
   logic [LW-1:0]   lut_ptr, lut_ptr_next;
   logic            beat;
   logic [NUM_LUTS-1:0] rd;

   assign cfg_ready = (state == LOAD);
   assign cfg_busy  = (state == LOAD);
   assign cfg_done  = (state == DONE);

   // A beat coinciding with a restart is dropped, not written or counted.
   assign beat = (state == LOAD) && cfg_valid && !cfg_start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         bit_ptr <= '0;
         lut_ptr <= '0;
      end else begin
         state   <= state_next;
         bit_ptr <= bit_ptr_next;
         lut_ptr <= lut_ptr_next;
      end
   end

   always_comb begin
      state_next   = state;
      bit_ptr_next = bit_ptr;
      lut_ptr_next = lut_ptr;
      if (cfg_start) begin
         state_next   = LOAD;
         bit_ptr_next = '0;
         lut_ptr_next = '0;
      end else if (beat) begin
         bit_ptr_next = bit_ptr + STEP;
         if (bit_ptr == LAST_BIT) begin
            if (lut_ptr == LAST_LUT) begin
               lut_ptr_next = '0;
               state_next   = DONE;
            end else begin
               lut_ptr_next = lut_ptr + LW'(1);
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LUTS; gi++) begin : g_lut
         logic [DEPTH-1:0] mem;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               mem <= '0;
            end else if (beat && (lut_ptr == LW'(gi))) begin
               mem[bit_ptr +: CFG_W] <= cfg_data;
            end
         end

         assign rd[gi] = mem[lut_in[gi*K +: K]];
      end

      if (REG_OUT != 0) begin : g_reg_out
         logic [NUM_LUTS-1:0] out_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               out_q <= '0;
            end else begin
               out_q <= cfg_done ? rd : '0;
            end
         end

         assign lut_out = out_q;
      end else begin : g_comb_out
         assign lut_out = cfg_done ? rd : '0;
      end
   endgenerate

endmodule

// File: tb/tb_lut_array_cfg.sv
// Scoreboard bench for lut_array_cfg (K=4, two LUTs, 4-bit beats); a combinational
// and a registered-output instance share all stimulus.
module tb_lut_array_cfg;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cfg_start = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [3:0] cfg_data = 4'h0;
   logic [7:0] lut_in = 8'h00;

   logic       rdy0, busy0, done0, rdy1, busy1, done1;
   logic [1:0] out0, out1;

   always #5 clk = ~clk;

   lut_array_cfg #(.K(4), .NUM_LUTS(2), .CFG_W(4), .REG_OUT(0)) dut_comb (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_data(cfg_data), .cfg_ready(rdy0), .cfg_busy(busy0), .cfg_done(done0),
      .lut_in(lut_in), .lut_out(out0)
   );

   lut_array_cfg #(.K(4), .NUM_LUTS(2), .CFG_W(4), .REG_OUT(1)) dut_reg (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_data(cfg_data), .cfg_ready(rdy1), .cfg_busy(busy1), .cfg_done(done1),
      .lut_in(lut_in), .lut_out(out1)
   );

   // kinds: 0 comb lut_out, 1 registered lut_out, 2 ready, 3 busy, 4 done
   typedef struct {
      int         kind;
      int         test;
      logic [1:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;

   // LUT0 = AND4 (bits 0..15: only bit 15 set), LUT1 = XOR4 (0x6996)
   logic [3:0] beats [8] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h6, 4'h9, 4'h9, 4'h6};

   function automatic logic [1:0] model(input logic [7:0] v);
      return {^v[7:4], &v[3:0]};
   endfunction

   function automatic string kname(input int kind);
      case (kind)
         0:       return "lut_out_comb";
         1:       return "lut_out_reg";
         2:       return "cfg_ready";
         3:       return "cfg_busy";
         4:       return "cfg_done";
         default: return "unknown";
      endcase
   endfunction

   task automatic expect_v(input int kind, input int test, input logic [1:0] exp);
      exp_t e;
      e.kind = kind;
      e.test = test;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t       e;
      logic [1:0] act;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            0:       act = out0;
            1:       act = out1;
            2:       act = {1'b0, rdy0};
            3:       act = {1'b0, busy0};
            4:       act = {1'b0, done0};
            default: act = 2'bxx;
         endcase
         n_checks++;
         if (act === e.exp) n_pass++;
         else $display("FAIL %s (test %0d): actual %b, required %b",
                       kname(e.kind), e.test, act, e.exp);
      end
   end

   task automatic start_load(input int t);
      cfg_start = 1'b1;
      cfg_valid = 1'b0;
      tick();
      cfg_start = 1'b0;
      expect_v(2, t, 2'b01);
      expect_v(3, t, 2'b01);
      expect_v(4, t, 2'b00);
   endtask

   task automatic load_seq(input int t, input bit toggle, input bit zero);
      for (int i = 0; i < 8; i++) begin
         if (toggle && i > 0) begin
            cfg_valid = 1'b0;
            cfg_data  = 4'hF;
            expect_v(2, t, 2'b01);
            tick();
         end
         cfg_valid = 1'b1;
         cfg_data  = zero ? 4'h0 : beats[i];
         if (i == 7) expect_v(4, t, 2'b00);
         tick();
      end
      cfg_valid = 1'b0;
      expect_v(4, t, 2'b01);
      expect_v(2, t, 2'b00);
      expect_v(3, t, 2'b00);
   endtask

   task automatic sweep(input int t, input bit zero);
      for (int v = 0; v < 256; v++) begin
         lut_in = 8'(v);
         expect_v(0, t, zero ? 2'b00 : model(8'(v)));
         tick();
      end
   endtask

   initial begin
      // Test 1: unconfigured array reads 0 and ignores beats
      tick();
      tick();
      reset = 1'b0;
      for (int v = 0; v < 256; v++) begin
         lut_in    = 8'(v);
         cfg_valid = 1'($urandom);
         cfg_data  = 4'($urandom);
         expect_v(0, 1, 2'b00);
         expect_v(1, 1, 2'b00);
         expect_v(2, 1, 2'b00);
         expect_v(4, 1, 2'b00);
         tick();
      end
      cfg_valid = 1'b0;

      // Test 2: back-to-back load, then beats in DONE must be ignored
      start_load(2);
      load_seq(2, 1'b0, 1'b0);
      cfg_valid = 1'b1;
      cfg_data  = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_v(2, 2, 2'b00);
         expect_v(4, 2, 2'b01);
      end
      cfg_valid = 1'b0;
      sweep(2, 1'b0);

      // Test 3: valid toggling
      start_load(3);
      load_seq(3, 1'b1, 1'b0);
      sweep(3, 1'b0);

      // Test 4: restart after 5 beats with a coincident beat
      start_load(4);
      for (int i = 0; i < 5; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = beats[i];
         tick();
      end
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 4'hF;
      tick();
      cfg_start = 1'b0;
      expect_v(2, 4, 2'b01);
      expect_v(4, 4, 2'b00);
      load_seq(4, 1'b0, 1'b0);
      sweep(4, 1'b0);

      // Test 5: mid-load reset, then all-zero load
      start_load(5);
      for (int i = 0; i < 3; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = beats[i];
         tick();
      end
      cfg_valid = 1'b0;
      lut_in    = 8'hFF;
      reset     = 1'b1;
      expect_v(0, 5, 2'b00);
      expect_v(1, 5, 2'b00);
      expect_v(2, 5, 2'b00);
      expect_v(3, 5, 2'b00);
      expect_v(4, 5, 2'b00);
      tick();
      reset = 1'b0;
      tick();
      expect_v(2, 5, 2'b00);
      expect_v(3, 5, 2'b00);
      expect_v(4, 5, 2'b00);
      start_load(5);
      load_seq(5, 1'b0, 1'b1);
      sweep(5, 1'b1);

      // Test 6: registered output latency and asynchronous reset
      start_load(6);
      lut_in = 8'hFF;
      load_seq(6, 1'b0, 1'b0);
      expect_v(0, 6, 2'b01);
      expect_v(1, 6, 2'b00);
      tick();
      expect_v(1, 6, 2'b01);
      lut_in = 8'h00;
      expect_v(0, 6, 2'b00);
      expect_v(1, 6, 2'b01);
      tick();
      expect_v(1, 6, 2'b00);
      lut_in = 8'h1F;
      tick();
      expect_v(1, 6, 2'b11);
      lut_in = 8'h70;
      tick();
      expect_v(1, 6, 2'b10);
      tick();
      reset = 1'b1;
      expect_v(1, 6, 2'b00);
      expect_v(0, 6, 2'b00);
      tick();
      reset = 1'b0;
      tick();
      tick();

      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lut_array_cfg.md
# lut_array_cfg

Parametrised array of NUM_LUTS configurable K-input LUTs with an on-chip configuration loader. Each LUT's truth table is loaded through a valid/ready configuration stream; an FSM sequences the bit and LUT address counters. Outputs are forced to 0 until a complete configuration has been loaded. The block replaces per-LUT LUTRAM write ports in overlay tiles with one shared, serialised configuration path, and can be built with or without a registered output stage.

## Interface

Parameters:
- K, 6: LUT input count. Each LUT holds 2^K bits.
- NUM_LUTS, 8: number of LUTs in the array.
- CFG_W, 8: configuration bits per beat. Must be a power of two, at most 2^K.
- REG_OUT, 0: 0 gives combinational read; 1 gives registered read with 1-cycle latency.

Ports:
- clk, input, 1: single clock. All state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- cfg_start, input, 1: single-cycle pulse that begins or restarts a configuration load.
- cfg_valid, input, 1: configuration beat valid.
- cfg_data, input, CFG_W: configuration beat. Bit 0 holds the lowest truth-table address.
- cfg_ready, output, 1: beat accepted when cfg_valid and cfg_ready are both high.
- cfg_busy, output, 1: high while in state LOAD.
- cfg_done, output, 1: high when a full configuration is loaded.
- lut_in, input, NUM_LUTS*K: LUT i reads address lut_in[i*K +: K].
- lut_out, output, NUM_LUTS: LUT i output is lut_out[i].

## Operation

- Storage is NUM_LUTS × 2^K flops, named mem[i][a].
- Counters:
  - bit_ptr is K bits wide and steps by CFG_W.
  - lut_ptr is clog2(NUM_LUTS) bits wide, minimum 1.
- FSM states are IDLE, LOAD and DONE.
- Reset (asynchronous): state = IDLE, all mem = 0, bit_ptr = 0, lut_ptr = 0, cfg_ready = 0, cfg_busy = 0, cfg_done = 0, lut_out = 0 (including the REG_OUT output register).
- IDLE or DONE, cfg_start = 1: go to LOAD and clear both counters. cfg_done drops the next cycle.
- LOAD:
  - cfg_ready = 1, cfg_busy = 1.
  - On an accepted beat: mem[lut_ptr][bit_ptr + j] = cfg_data[j] for j = 0..CFG_W-1, then bit_ptr += CFG_W.
  - When bit_ptr wraps from 2^K-CFG_W to 0, lut_ptr increments.
- Final beat is lut_ptr = NUM_LUTS-1 with bit_ptr = 2^K-CFG_W. The next state is DONE, with cfg_ready = 0, cfg_busy = 0 and cfg_done = 1.
- A full load takes exactly NUM_LUTS*2^K/CFG_W beats.
- cfg_start during LOAD restarts the load:
  - Counters return to 0.
  - A beat presented in the same cycle is discarded and not counted.
  - Existing mem contents stay until overwritten.
- cfg_valid in IDLE or DONE is ignored, since cfg_ready = 0. mem is unchanged.
- Read path: lut_out[i] = cfg_done ? mem[i][lut_in[i*K +: K]] : 0.
- No other write path exists. mem is frozen outside LOAD.
- A mid-load reset discards the partial load. The array behaves exactly as after power-up.

## Timing

- cfg_ready and cfg_busy are registered from state, with no combinational dependence on cfg_valid or cfg_start.
- Beat-to-storage latency is 1 cycle. The value written is visible at lut_out one cycle after the final beat, when cfg_done rises.
- REG_OUT = 0: lut_out follows lut_in combinationally once cfg_done = 1.
- REG_OUT = 1: lut_out is registered. lut_in sampled at edge n appears after edge n. The first valid output is one cycle after cfg_done rises.
- Maximum throughput is one beat per cycle with cfg_valid held high.
- The block never deasserts cfg_ready mid-load except on cfg_start (restart) or reset.

## Test plan

Bench parameters: K=4, NUM_LUTS=2, CFG_W=4 (8 beats), REG_OUT=0 unless stated.

1. Reset, then sweep lut_in over all 256 values → lut_out = 0, cfg_ready = 0, cfg_done = 0 throughout. Values driven on cfg_valid/cfg_data are ignored.
2. cfg_start, then beats 0,0,0,8,6,9,9,6 back-to-back → cfg_done = 1 exactly one cycle after the 8th beat. LUT0 = AND4: lut_out[0] = 1 only for input 4'hF. LUT1 = XOR4: lut_out[1] = parity of input.
3. Same load with cfg_valid toggled 1,0,1,0 → identical result. Only valid&ready cycles advance bit_ptr. The transfer spans 15 cycles.
4. After 5 beats of a load, assert cfg_start together with cfg_valid (data F) → that beat is dropped. The following 8 beats 0,0,0,8,6,9,9,6 produce the same outputs as test 2.
5. Assert reset after 3 beats → immediately lut_out = 0 and cfg_busy = 0. After release, the state is IDLE and mem reads back all zeros after a full all-zero load.
6. REG_OUT=1 with the load from test 2, then drive lut_in = 8'hFF → lut_out = 2'b01 appears one edge later. With reset asserted, lut_out = 0 asynchronously.
